// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_pkg
// Description : Immediate format encodings and default datapath width.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_pkg;

    localparam int IMM_XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_S     = 3'b001,
        IMM_B     = 3'b010,
        IMM_U     = 3'b011,
        IMM_J     = 3'b100,
        IMM_SHAMT = 3'b101
    } imm_src_e;

endpackage : imm_pkg
`default_nettype wire

// File: rtl/imm_format.sv
`default_nettype none
// ============================================================================
// Module      : imm_format
// Description : Combinational immediate decoder (format select -> immediate).
// Revision    : 1.0 - initial release
// ============================================================================
module imm_format
    import imm_pkg::*;
#(
    parameter int XLEN = IMM_XLEN_DEFAULT
) (
    input  logic [2:0]      i_imm_src,
    input  logic [24:0]     i_instr,
    output logic [XLEN-1:0] o_imm,
    output logic            o_err
);

    // Re-index so slices read exactly like the architectural bit numbers.
    logic [31:7]     w_ins;
    logic [XLEN-1:0] w_shamt;

    assign w_ins = i_instr;

    generate
        if (XLEN == 64) begin : g_shamt_rv64
            assign w_shamt = XLEN'(w_ins[25:20]);
        end else begin : g_shamt_rv32
            assign w_shamt = XLEN'(w_ins[24:20]);
        end
    endgenerate

    always_comb begin
        o_imm = '0;
        o_err = 1'b0;
        case (i_imm_src)
            IMM_I:     o_imm = XLEN'($signed(w_ins[31:20]));
            IMM_S:     o_imm = XLEN'($signed({w_ins[31:25], w_ins[11:7]}));
            IMM_B:     o_imm = XLEN'($signed({w_ins[31], w_ins[7], w_ins[30:25],
                                              w_ins[11:8], 1'b0}));
            IMM_U:     o_imm = XLEN'($signed({w_ins[31:12], 12'b0}));
            IMM_J:     o_imm = XLEN'($signed({w_ins[31], w_ins[19:12], w_ins[20],
                                              w_ins[30:21], 1'b0}));
            IMM_SHAMT: o_imm = w_shamt;
            default:   o_err = 1'b1;
        endcase
    end

endmodule : imm_format
`default_nettype wire

// File: rtl/imm_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_pipe
// Description : One-cycle immediate extender with output + skid buffering.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = IMM_XLEN_DEFAULT,
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       imm_src,
    input  logic [24:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_ext,
    output logic             imm_err,
    output logic [ERR_W-1:0] err_cnt
);

    logic [XLEN-1:0]  w_fmt_imm;
    logic             w_fmt_err;
    logic             w_accept;
    logic             w_drain;

    logic             r_out_valid_q, w_out_valid_d;
    logic [XLEN-1:0]  r_out_imm_q,   w_out_imm_d;
    logic             r_out_err_q,   w_out_err_d;
    logic             r_skid_full_q, w_skid_full_d;
    logic [XLEN-1:0]  r_skid_imm_q,  w_skid_imm_d;
    logic             r_skid_err_q,  w_skid_err_d;
    logic             r_in_ready_q,  w_in_ready_d;
    logic [ERR_W-1:0] r_err_cnt_q,   w_err_cnt_d;

    imm_format #(
        .XLEN (XLEN)
    ) u_imm_format (
        .i_imm_src (imm_src),
        .i_instr   (instr),
        .o_imm     (w_fmt_imm),
        .o_err     (w_fmt_err)
    );

    assign w_accept = in_valid && r_in_ready_q;
    assign w_drain  = r_out_valid_q && out_ready;

    always_comb begin
        w_out_valid_d = r_out_valid_q;
        w_out_imm_d   = r_out_imm_q;
        w_out_err_d   = r_out_err_q;
        w_skid_full_d = r_skid_full_q;
        w_skid_imm_d  = r_skid_imm_q;
        w_skid_err_d  = r_skid_err_q;
        w_err_cnt_d   = r_err_cnt_q;

        if (flush) begin
            w_out_valid_d = 1'b0;
            w_skid_full_d = 1'b0;
        end else if (!r_out_valid_q || w_drain) begin
            // Output slot frees up: the older skid entry always goes first.
            if (r_skid_full_q) begin
                w_out_valid_d = 1'b1;
                w_out_imm_d   = r_skid_imm_q;
                w_out_err_d   = r_skid_err_q;
                w_skid_full_d = 1'b0;
            end else if (w_accept) begin
                w_out_valid_d = 1'b1;
                w_out_imm_d   = w_fmt_imm;
                w_out_err_d   = w_fmt_err;
            end else begin
                w_out_valid_d = 1'b0;
            end
        end else if (w_accept) begin
            w_skid_full_d = 1'b1;
            w_skid_imm_d  = w_fmt_imm;
            w_skid_err_d  = w_fmt_err;
        end

        if (!flush && w_accept && w_fmt_err && (r_err_cnt_q != '1)) begin
            w_err_cnt_d = r_err_cnt_q + ERR_W'(1);
        end

        w_in_ready_d = !w_skid_full_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid_q <= 1'b0;
            r_out_imm_q   <= '0;
            r_out_err_q   <= 1'b0;
            r_skid_full_q <= 1'b0;
            r_skid_imm_q  <= '0;
            r_skid_err_q  <= 1'b0;
            r_in_ready_q  <= 1'b0;
            r_err_cnt_q   <= '0;
        end else begin
            r_out_valid_q <= w_out_valid_d;
            r_out_imm_q   <= w_out_imm_d;
            r_out_err_q   <= w_out_err_d;
            r_skid_full_q <= w_skid_full_d;
            r_skid_imm_q  <= w_skid_imm_d;
            r_skid_err_q  <= w_skid_err_d;
            r_in_ready_q  <= w_in_ready_d;
            r_err_cnt_q   <= w_err_cnt_d;
        end
    end

    assign in_ready  = r_in_ready_q;
    assign out_valid = r_out_valid_q;
    assign imm_ext   = r_out_imm_q;
    assign imm_err   = r_out_err_q;
    assign err_cnt   = r_err_cnt_q;

endmodule : imm_ext_pipe
`default_nettype wire

// File: tb/tb_imm_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_ext_pipe
// Description : Self-checking bench for imm_ext_pipe (XLEN 32 and 64 copies).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  imm_src = 3'b000;
    logic [24:0] instr = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, imm_err;
    logic [31:0] imm_ext;
    logic [15:0] err_cnt;
    logic        in_ready_64, out_valid_64, imm_err_64;
    logic [63:0] imm_ext_64;
    logic [15:0] err_cnt_64;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] i32;
        logic [63:0] i64;
        logic        err;
    } ent_t;

    ent_t q[$];
    int   cnt_m = 0;

    imm_ext_pipe #(.XLEN(32), .ERR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .imm_src(imm_src), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready), .imm_ext(imm_ext),
        .imm_err(imm_err), .err_cnt(err_cnt)
    );

    imm_ext_pipe #(.XLEN(64), .ERR_W(16)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready_64), .imm_src(imm_src), .instr(instr),
        .out_valid(out_valid_64), .out_ready(out_ready), .imm_ext(imm_ext_64),
        .imm_err(imm_err_64), .err_cnt(err_cnt_64)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Interpret 'raw' as a two's-complement number of 'bits' bits.
    function automatic longint sx(input longint raw, input int bits);
        longint half;
        half = longint'(1) << (bits - 1);
        return (raw >= half) ? raw - (half * 2) : raw;
    endfunction

    function automatic logic [63:0] ref_imm(input logic [2:0] src, input logic [31:0] ins,
                                            input int xlen);
        longint v;
        case (src)
            3'd0: v = sx(longint'(ins[31:20]), 12);
            3'd1: v = sx(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
            3'd2: v = sx(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                         longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
            3'd3: v = sx(longint'(ins[31:12]) * 4096, 32);
            3'd4: v = sx(longint'(ins[31]) * (1 << 20) + longint'(ins[19:12]) * (1 << 12) +
                         longint'(ins[20]) * (1 << 11) + longint'(ins[30:21]) * 2, 21);
            3'd5: v = (xlen == 32) ? longint'(ins[24:20]) : longint'(ins[25:20]);
            default: v = 0;
        endcase
        return (xlen == 32) ? {32'h0, v[31:0]} : v;
    endfunction

    // One clock of stimulus; outputs checked against the model mid-cycle.
    task automatic cycle(input logic v, input logic [2:0] src, input logic [31:0] ins,
                         input logic ordy, input logic fl);
        logic acc, drn;
        ent_t e;
        in_valid  = v;
        imm_src   = src;
        instr     = ins[31:7];
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        chk("in_ready", in_ready, q.size() < 2);
        chk("in_ready_64", in_ready_64, q.size() < 2);
        chk("out_valid", out_valid, q.size() > 0);
        chk("out_valid_64", out_valid_64, q.size() > 0);
        if (q.size() > 0) begin
            chk("imm_ext_32", imm_ext, q[0].i32);
            chk("imm_ext_64", imm_ext_64, q[0].i64);
            chk("imm_err", imm_err, q[0].err);
        end
        chk("err_cnt", err_cnt, cnt_m);
        acc = v && (q.size() < 2);
        drn = ordy && (q.size() > 0);
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) begin
                e.i32 = ref_imm(src, ins, 32);
                e.i64 = ref_imm(src, ins, 64);
                e.err = (src > 3'd5);
                q.push_back(e);
                if (e.err && cnt_m < 65535) cnt_m++;
            end
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_valid_64", out_valid_64, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_imm_ext", imm_ext, 32'h0);
        chk("rst_imm_err", imm_err, 1'b0);
        chk("rst_err_cnt", err_cnt, 16'h0);
        q.delete();
        cnt_m = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready_rise", in_ready, 1'b1);
    endtask

    task automatic directed(input string tag, input logic [2:0] src, input logic [31:0] ins,
                            input logic [31:0] e32, input logic [63:0] e64);
        cycle(1'b1, src, ins, 1'b1, 1'b0);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_32"}, imm_ext, e32);
        chk({tag, "_64"}, imm_ext_64, e64);
        chk({tag, "_err"}, imm_err, 1'b0);
        cycle(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        directed("dir_I", 3'd0, 32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
        directed("dir_B", 3'd2, 32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
        directed("dir_J", 3'd4, 32'hFF9FF06F, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8);
        directed("dir_U", 3'd3, 32'h123450B7, 32'h12345000, 64'h0000000012345000);

        // Illegal format travels with its entry.
        cycle(1'b1, 3'd7, 32'hFFFFFFFF, 1'b1, 1'b0);
        chk("illegal_err", imm_err, 1'b1);
        chk("illegal_imm", imm_ext, 32'h0);
        chk("illegal_cnt", err_cnt, 16'd1);
        cycle(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);

        // Stall: three offers, two accepted, then drain in order.
        cycle(1'b1, 3'd0, 32'h00100013, 1'b0, 1'b0);
        cycle(1'b1, 3'd5, 32'h03F00013, 1'b0, 1'b0);
        chk("stall_in_ready_low", in_ready, 1'b0);
        cycle(1'b1, 3'd1, 32'hFE000FA3, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);

        // Flush with both entries held beats a simultaneous offer.
        cycle(1'b1, 3'd7, 32'h12345678, 1'b0, 1'b0);
        cycle(1'b1, 3'd0, 32'h80000000, 1'b0, 1'b0);
        cycle(1'b1, 3'd6, 32'h0, 1'b0, 1'b1);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        cycle(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);

        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom(),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
        end

        // Asynchronous reset while stalled with two entries.
        cycle(1'b1, 3'd2, 32'h00000063, 1'b0, 1'b0);
        cycle(1'b1, 3'd4, 32'h0000006F, 1'b0, 1'b0);
        do_reset();

        for (int i = 1; i <= 65537; i++) begin
            cycle(1'b1, 3'($urandom_range(6, 7)), $urandom(), 1'b1, 1'b0);
            if (i == 65535 || i == 65536 || i == 65537) chk("sat_err_cnt", err_cnt, 16'hFFFF);
        end
        cycle(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_imm_ext_pipe
`default_nettype wire
